// File: rtl/fp_conv_pkg.sv
// ---------------------------------------------------------------------------
// fp_conv_pkg
// Shared definitions for the 12-bit two's-complement to 8-bit float converter
// (1 sign bit, 3-bit exponent, 4-bit significand).
//   D_W/E_W/F_W : sample, exponent and significand widths
//   E_MAX       : largest exponent, also the starting exponent before normalizing
//   NORM_PAD    : number of NORM cycles when the fixed-latency mode is selected
//   state_t     : sequencer states
// ---------------------------------------------------------------------------
package fp_conv_pkg;

  localparam int D_W      = 12;
  localparam int E_W      = 3;
  localparam int F_W      = 4;
  localparam int NORM_PAD = 8;

  localparam logic [E_W-1:0] E_MAX = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    RND,
    OUT
  } state_t;

endpackage

// File: rtl/fp_conv_ctrl_if.sv
// ---------------------------------------------------------------------------
// fp_conv_ctrl_if
// Sample/result handshake bundle for fp_conv_ctrl.
//   in_valid/in_ready/in_d          : sample handshake (producer -> converter)
//   out_valid/out_ready/out_s/e/f   : result handshake (converter -> consumer)
//   busy                            : converter is not idle
// The master modport is the producer/consumer side, slave is the converter.
// ---------------------------------------------------------------------------
interface fp_conv_ctrl_if;
  import fp_conv_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [D_W-1:0] in_d;
  logic           out_valid;
  logic           out_ready;
  logic           out_s;
  logic [E_W-1:0] out_e;
  logic [F_W-1:0] out_f;
  logic           busy;

  modport master (
    output in_valid, in_d, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_f, busy
  );

  modport slave (
    input  in_valid, in_d, out_ready,
    output in_ready, out_valid, out_s, out_e, out_f, busy
  );

endinterface

// File: rtl/fp_round.sv
// ---------------------------------------------------------------------------
// fp_round
// Combinational round-half-up of a 4-bit significand using one round bit.
//   f_in, r, e_in : truncated significand, round bit, exponent
//   f_out, e_out  : rounded significand and exponent
// A significand overflow renormalizes to 1000 with the exponent bumped; at
// the largest exponent the result saturates at f=15 instead.
// ---------------------------------------------------------------------------
module fp_round
  import fp_conv_pkg::*;
(
  input  logic [F_W-1:0] f_in,
  input  logic           r,
  input  logic [E_W-1:0] e_in,
  output logic [F_W-1:0] f_out,
  output logic [E_W-1:0] e_out
);

  always_comb begin
    f_out = f_in;
    e_out = e_in;
    if (r) begin
      if (f_in != 4'hF) begin
        f_out = f_in + 4'd1;
      end else if (e_in != E_MAX) begin
        f_out = 4'h8;
        e_out = e_in + 3'd1;
      end
    end
  end

endmodule

// File: rtl/fp_conv_ctrl.sv
// ---------------------------------------------------------------------------
// fp_conv_ctrl
// Multi-cycle sequencer converting a 12-bit two's-complement sample into the
// 8-bit float format. One sample in flight, registered result held until taken.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : fp_conv_ctrl_if slave (sample in, result out, busy)
//   FIXED_LAT : 1 pads normalization to NORM_PAD cycles (constant latency 10)
// ---------------------------------------------------------------------------
module fp_conv_ctrl
  import fp_conv_pkg::*;
#(
  parameter bit FIXED_LAT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  fp_conv_ctrl_if.slave bus
);

  state_t         state;
  state_t         state_nxt;
  logic [D_W-1:0] d_reg;
  logic [D_W-1:0] m_reg;
  logic [E_W-1:0] e_reg;
  logic           s_reg;
  logic [2:0]     norm_cnt;
  logic           out_s_reg;
  logic [E_W-1:0] out_e_reg;
  logic [F_W-1:0] out_f_reg;
  logic [D_W-1:0] abs_val;
  logic [F_W-1:0] f_rnd;
  logic [E_W-1:0] e_rnd;
  logic           shift_ok;
  logic           norm_done;

  // -2048 has no positive 12-bit counterpart, so it saturates to 2047.
  always_comb begin
    abs_val = d_reg;
    if (d_reg[D_W-1]) begin
      if (d_reg == 12'h800) abs_val = 12'h7FF;
      else                  abs_val = -d_reg;
    end
  end

  // Shift until the hidden-one position (bit 10) is set or the exponent
  // bottoms out; the fixed-latency mode just keeps counting after that.
  assign shift_ok  = !m_reg[10] && (e_reg != '0);
  assign norm_done = FIXED_LAT ? (norm_cnt == 3'(NORM_PAD - 1)) : !shift_ok;

  fp_round u_round (
    .f_in  (m_reg[10:7]),
    .r     (m_reg[6]),
    .e_in  (e_reg),
    .f_out (f_rnd),
    .e_out (e_rnd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = ABS;
      ABS:                        state_nxt = NORM;
      NORM:    if (norm_done)     state_nxt = RND;
      RND:                        state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: sample capture, magnitude/normalize shifter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg     <= '0;
      m_reg     <= '0;
      e_reg     <= '0;
      s_reg     <= 1'b0;
      norm_cnt  <= '0;
      out_s_reg <= 1'b0;
      out_e_reg <= '0;
      out_f_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) d_reg <= bus.in_d;
        end
        ABS: begin
          s_reg    <= d_reg[D_W-1];
          m_reg    <= abs_val;
          e_reg    <= E_MAX;
          norm_cnt <= '0;
        end
        NORM: begin
          if (shift_ok) begin
            m_reg <= m_reg << 1;
            e_reg <= e_reg - 3'd1;
          end
          norm_cnt <= norm_cnt + 3'd1;
        end
        RND: begin
          out_s_reg <= s_reg;
          out_e_reg <= e_rnd;
          out_f_reg <= f_rnd;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_s     = out_s_reg;
  assign bus.out_e     = out_e_reg;
  assign bus.out_f     = out_f_reg;

endmodule

// File: tb/tb_fp_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fp_conv_ctrl
// Directed bench for fp_conv_ctrl. Two instances run side by side: dut0 with
// data-dependent latency and dut1 with fixed latency. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fp_conv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_conv_ctrl_if bus0 ();
  fp_conv_ctrl_if bus1 ();

  fp_conv_ctrl #(.FIXED_LAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fp_conv_ctrl #(.FIXED_LAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic get_valid(input int w);
    return (w == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? bus0.busy : bus1.busy;
  endfunction

  // Result packed as {s, e, f}.
  function automatic logic [7:0] get_res(input int w);
    return (w == 0) ? {bus0.out_s, bus0.out_e, bus0.out_f}
                    : {bus1.out_s, bus1.out_e, bus1.out_f};
  endfunction

  task automatic drive_in(input int w, input logic v, input logic [11:0] d);
    if (w == 0) begin
      bus0.in_valid = v;
      bus0.in_d     = d;
    end else begin
      bus1.in_valid = v;
      bus1.in_d     = d;
    end
  endtask

  task automatic drive_out_ready(input int w, input logic v);
    if (w == 0) bus0.out_ready = v;
    else        bus1.out_ready = v;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle in_valid pulse; returns on the falling edge after the accept edge.
  task automatic applyStimulus(input int w, input logic [11:0] d);
    drive_in(w, 1'b1, d);
    @(negedge clk);
    drive_in(w, 1'b0, d);
  endtask

  // Counts clock edges since the accept edge until out_valid, bounded.
  task automatic wait_valid(input int w, output int cnt);
    cnt = 0;
    while (!get_valid(w) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic take_output(input int w);
    drive_out_ready(w, 1'b1);
    @(negedge clk);
    drive_out_ready(w, 1'b0);
  endtask

  task automatic run_conv(input int w, input logic [11:0] d, input logic s,
                          input logic [2:0] e, input logic [3:0] f,
                          input int lat, input string tag);
    int cnt;
    @(negedge clk);
    checkOutput({tag, "_rdy_pre"}, 16'(get_ready(w)), 16'd1);
    applyStimulus(w, d);
    checkOutput({tag, "_busy"}, 16'(get_busy(w)), 16'd1);
    wait_valid(w, cnt);
    checkOutput({tag, "_lat"}, 16'(cnt), 16'(lat));
    checkOutput({tag, "_res"}, 16'(get_res(w)), 16'({s, e, f}));
    take_output(w);
    checkOutput({tag, "_rdy_post"}, 16'(get_ready(w)), 16'd1);
    checkOutput({tag, "_ovld_post"}, 16'(get_valid(w)), 16'd0);
  endtask

  initial begin
    int cnt;
    drive_in(0, 1'b0, 12'h000);
    drive_in(1, 1'b0, 12'h000);
    drive_out_ready(0, 1'b0);
    drive_out_ready(1, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_rdy0",  16'(get_ready(0)), 16'd1);
    checkOutput("rst_busy0", 16'(get_busy(0)),  16'd0);
    checkOutput("rst_ovld0", 16'(get_valid(0)), 16'd0);
    checkOutput("rst_res0",  16'(get_res(0)),   16'd0);
    checkOutput("rst_rdy1",  16'(get_ready(1)), 16'd1);
    checkOutput("rst_ovld1", 16'(get_valid(1)), 16'd0);

    // Extremes and denormal, both latency modes
    run_conv(0, 12'hFF3, 1'b1, 3'd0, 4'd13, 10, "m13_v");
    run_conv(1, 12'hFF3, 1'b1, 3'd0, 4'd13, 10, "m13_f");
    run_conv(0, 12'h7FF, 1'b0, 3'd7, 4'd15, 3,  "max_v");
    run_conv(1, 12'h7FF, 1'b0, 3'd7, 4'd15, 10, "max_f");
    run_conv(0, 12'h800, 1'b1, 3'd7, 4'd15, 3,  "min_v");
    run_conv(0, 12'h000, 1'b0, 3'd0, 4'd0,  10, "zero_v");
    run_conv(1, 12'h000, 1'b0, 3'd0, 4'd0,  10, "zero_f");

    // Rounding cases
    run_conv(0, 12'd44, 1'b0, 3'd2, 4'd11, 8,  "rnd44");
    run_conv(0, 12'd46, 1'b0, 3'd2, 4'd12, 8,  "rnd46");
    run_conv(0, 12'd63, 1'b0, 3'd3, 4'd8,  8,  "rnd63");
    run_conv(1, 12'd63, 1'b0, 3'd3, 4'd8,  10, "rnd63_f");
    run_conv(1, 12'd44, 1'b0, 3'd2, 4'd11, 10, "rnd44_f");

    // Backpressure: result held, new samples ignored while OUT waits
    @(negedge clk);
    applyStimulus(0, 12'd44);
    wait_valid(0, cnt);
    checkOutput("bp_lat", 16'(cnt), 16'd8);
    for (int i = 0; i < 5; i++) begin
      drive_in(0, (i % 2) == 0, 12'h7FF);
      @(negedge clk);
      checkOutput("bp_ovld", 16'(get_valid(0)), 16'd1);
      checkOutput("bp_res",  16'(get_res(0)),   16'h002B);
      checkOutput("bp_rdy",  16'(get_ready(0)), 16'd0);
    end
    drive_in(0, 1'b0, 12'h7FF);
    take_output(0);
    checkOutput("bp_rdy_after",  16'(get_ready(0)), 16'd1);
    checkOutput("bp_ovld_after", 16'(get_valid(0)), 16'd0);
    run_conv(0, 12'd46, 1'b0, 3'd2, 4'd12, 8, "bp_next");

    // Reset during NORM; dut1 sees in_valid together with rst
    @(negedge clk);
    applyStimulus(0, 12'h001);
    @(negedge clk);
    checkOutput("nrst_busy_pre", 16'(get_busy(0)), 16'd1);
    rst = 1'b1;
    drive_in(1, 1'b1, 12'h7FF);
    @(negedge clk);
    rst = 1'b0;
    drive_in(1, 1'b0, 12'h7FF);
    checkOutput("nrst_rdy0",  16'(get_ready(0)), 16'd1);
    checkOutput("nrst_busy0", 16'(get_busy(0)),  16'd0);
    checkOutput("nrst_ovld0", 16'(get_valid(0)), 16'd0);
    checkOutput("nrst_res0",  16'(get_res(0)),   16'd0);
    checkOutput("nrst_rdy1",  16'(get_ready(1)), 16'd1);
    checkOutput("nrst_busy1", 16'(get_busy(1)),  16'd0);
    checkOutput("nrst_res1",  16'(get_res(1)),   16'd0);
    run_conv(0, 12'h7FF, 1'b0, 3'd7, 4'd15, 3,  "post_rst_v");
    run_conv(1, 12'h7FF, 1'b0, 3'd7, 4'd15, 10, "post_rst_f");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
